// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Multi-cycle wide adder sequencer. The two operands are latched on an accepted
// start and presented one nibble per cycle, LSB nibble first, to an external
// 4-bit full adder. The adder's sum nibble is shifted into the result from the
// top, and its carry is registered as the carry-in for the next nibble.
// Handshake: start / busy / done, with sum and cout held until the next accept.

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_s,
  input  logic                 fa_co
);

  localparam int W  = 4 * NIBBLES;
  // The counter needs at least one bit, even when only a single nibble is processed.
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            accept_s;
  logic            last_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic            carry_r;
  logic [CW-1:0]   count_r;
  logic [W-1:0]    sum_r;
  logic            cout_r;
  logic [W+3:0]    sum_ext_s;

  // The final nibble is the one being added while the counter reads NIBBLES-1.
  assign last_s    = (count_r == CW'(NIBBLES - 1));
  // The new nibble enters at the top; dropping the low nibble of this concatenation
  // gives the right-shifted result for any width, including a single nibble.
  assign sum_ext_s = {fa_s, sum_r};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. A start is accepted from IDLE, and also from DONE, so that
  // back-to-back operations are possible. A start seen during RUN is ignored.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        accept_s = 1'b0;
      end
    endcase
  end

  // Operand shifters, ripple carry, nibble counter and the held result.
  // sum keeps its old value on the accepting edge and is then overwritten one
  // nibble per RUN edge. cout is cleared on accept and loaded on the last RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {W{1'b0}};
      b_sh_r  <= {W{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      carry_r <= cin;
      count_r <= {CW{1'b0}};
      cout_r  <= 1'b0;
    end else if (state_r == RUN) begin
      a_sh_r  <= a_sh_r >> 4;
      b_sh_r  <= b_sh_r >> 4;
      carry_r <= fa_co;
      count_r <= count_r + CW'(1);
      sum_r   <= sum_ext_s[W+3:4];
      if (last_s) begin
        cout_r <= fa_co;
      end
    end
  end

  // The adder interface carries live data only in RUN and is quiet otherwise.
  always_comb begin
    fa_a   = 4'd0;
    fa_b   = 4'd0;
    fa_cin = 1'b0;
    if (state_r == RUN) begin
      fa_a   = a_sh_r[3:0];
      fa_b   = b_sh_r[3:0];
      fa_cin = carry_r;
    end else begin
      fa_a   = 4'd0;
      fa_b   = 4'd0;
      fa_cin = 1'b0;
    end
  end

  // Status and result outputs come straight from registers.
  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4). A 4-bit full adder is
// modelled in-line on the fa_* ports. Inputs change on the falling edge, and
// outputs are sampled on the falling edge, away from the active rising edge.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  fa_a;
  logic [3:0]  fa_b;
  logic        fa_cin;
  logic [3:0]  fa_s;
  logic        fa_co;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_s   (fa_s),
    .fa_co  (fa_co)
  );

  // External 4-bit full adder
  assign {fa_co, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {4'd0, fa_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request at the current falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    cin   = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required 0 0 0000 0",
               busy, done, sum, cout);
    end
    checks++;
    if (fa_a !== 4'h0 || fa_b !== 4'h0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_fa: fa_a=%h fa_b=%h fa_cin=%b, required 0 0 0", fa_a, fa_b, fa_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] an;
    logic [15:0] bn;
    an = 16'h1234;
    bn = 16'h4321;
    issue(16'h1234, 16'h4321, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
      end
      checks++;
      if (fa_a !== an[3:0] || fa_b !== bn[3:0]) begin
        errors++;
        $display("FAIL basic_nibble cycle %0d: fa_a=%h fa_b=%h, required %h %h",
                 k, fa_a, fa_b, an[3:0], bn[3:0]);
      end
      an = an >> 4;
      bn = bn >> 4;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    checks++;
    if (sum !== 16'h5555 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b, required 5555 0", sum, cout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_carry_ripple();
    issue(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (fa_cin !== ((k == 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL ripple_fa_cin cycle %0d: fa_cin=%b, required %b",
                 k, fa_cin, (k == 1) ? 1'b0 : 1'b1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL ripple_result: done=%b sum=%h cout=%b, required 1 0000 1", done, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL ones_result: done=%b sum=%h cout=%b, required 1 ffff 1", done, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int done_seen;
    done_seen = 0;
    issue(16'h1111, 16'h2222, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'b1;
      if (done) done_seen++;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL held_busy cycle %0d: busy=%b, required 1", k, busy);
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (done) done_seen++;
    checks++;
    if (sum !== 16'h3333 || cout !== 1'b0) begin
      errors++;
      $display("FAIL held_result: sum=%h cout=%b, required 3333 0", sum, cout);
    end
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 1) begin
      errors++;
      $display("FAIL held_done_count: saw %0d done pulses, required 1", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_prev_result: done=%b sum=%h cout=%b, required 1 ffff 1", done, sum, cout);
    end
    issue(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'hFFFF || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b sum=%h cout=%b, required 1 0 ffff 0",
               busy, done, sum, cout);
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 16'h1010 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: done=%b sum=%h cout=%b, required 1 1010 0", done, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    issue(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 ||
        fa_a !== 4'h0 || fa_b !== 4'h0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b sum=%h cout=%b fa=%h/%h/%b, required all 0",
               busy, done, sum, cout, fa_a, fa_b, fa_cin);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: saw %0d busy/done cycles after abort, required 0", done_seen);
    end
    issue(16'h0001, 16'h0002, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 16'h0003 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun: done=%b sum=%h cout=%b, required 1 0003 0", done, sum, cout);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_all_ones();
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
